// File: rtl/exp_sched_pkg.sv
// Shared types and constants for the exponent job scheduler.
package exp_sched_pkg;

  // Scheduler sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  // Default operand / result widths
  localparam int DEF_X_W = 4;
  localparam int DEF_A_W = 4;
  localparam int DEF_P_W = 15;

  // Response error encodings
  localparam logic RSP_OK      = 1'b0;
  localparam logic RSP_TIMEOUT = 1'b1;

endpackage

// File: rtl/exp_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie goes
// to the requester that was not served last.
module exp_rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_id,
  output logic grant_valid,
  output logic grant_id
);

  // Pick the winner from the current valids and the last served id
  always_comb begin
    grant_valid = valid0 | valid1;
    grant_id    = 1'b0;
    if (valid0 && valid1) begin
      grant_id = ~last_id;
    end else if (valid1) begin
      grant_id = 1'b1;
    end
  end

endmodule

// File: rtl/exponent_job_scheduler.sv
// Shares one exponent core between two requesters: arbitrates, captures
// operands, pulses load/start, waits for a done edge (with timeout) and
// returns a tagged result on a valid/ready channel.
module exponent_job_scheduler
  import exp_sched_pkg::*;
#(
  parameter int X_W     = DEF_X_W,
  parameter int A_W     = DEF_A_W,
  parameter int P_W     = DEF_P_W,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = $clog2(TIMEOUT)
) (
  input  logic           S_AXI_ACLK,
  input  logic           S_AXI_ARESETN,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [X_W-1:0] req0_x,
  input  logic [A_W-1:0] req0_a,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [X_W-1:0] req1_x,
  input  logic [A_W-1:0] req1_a,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [P_W-1:0] rsp_p,
  output logic           rsp_id,
  output logic           rsp_err,
  output logic           exp_load,
  output logic           exp_start,
  output logic [X_W-1:0] exp_x,
  output logic [A_W-1:0] exp_a,
  input  logic           exp_done,
  input  logic [P_W-1:0] exp_p,
  output logic           busy,
  output logic [15:0]    job_count
);

  // Last timer value before a WAIT is abandoned
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_reg;
  state_t          state_next;
  logic            last_id;
  logic            done_q;
  logic [TO_W-1:0] timer;
  logic            grant_valid;
  logic            grant_id;
  logic            done_rise;
  logic            timed_out;

  exp_rr_arbiter2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_id     (last_id),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // A level left high by a previous job is not an edge, so only a fresh
  // 0->1 transition counts as completion.
  assign done_rise = exp_done && !done_q;
  assign timed_out = (timer == TO_LAST);

  // Ready is combinational so the handshake completes in the grant cycle
  assign req0_ready = (state_reg == IDLE) && grant_valid && !grant_id;
  assign req1_ready = (state_reg == IDLE) && grant_valid &&  grant_id;

  // State register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; done wins over a coincident timeout
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = LOAD;
      LOAD:    state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (done_rise || timed_out) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs and datapath, derived from the upcoming state
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      exp_load  <= 1'b0;
      exp_start <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      rsp_err   <= RSP_OK;
      rsp_p     <= '0;
      rsp_id    <= 1'b0;
      exp_x     <= '0;
      exp_a     <= '0;
      job_count <= 16'd0;
      last_id   <= 1'b1;
      done_q    <= 1'b0;
      timer     <= '0;
    end else begin
      done_q    <= exp_done;
      exp_load  <= (state_next == LOAD);
      exp_start <= (state_next == START);
      rsp_valid <= (state_next == RESP);
      busy      <= (state_next != IDLE);
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            exp_x  <= grant_id ? req1_x : req0_x;
            exp_a  <= grant_id ? req1_a : req0_a;
            rsp_id <= grant_id;
          end
        end
        START: begin
          timer <= '0;
        end
        WAIT: begin
          if (done_rise) begin
            rsp_p   <= exp_p;
            rsp_err <= RSP_OK;
          end else if (timed_out) begin
            rsp_p   <= '0;
            rsp_err <= RSP_TIMEOUT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            last_id   <= rsp_id;
            job_count <= job_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exponent_job_scheduler.sv
// Self-checking bench for exponent_job_scheduler with a behavioural core model.
module tb_exponent_job_scheduler;

  localparam int TOUT = 16;

  logic        S_AXI_ACLK = 1'b0;
  logic        S_AXI_ARESETN;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_x, req0_a, req1_x, req1_a;
  logic        rsp_valid, rsp_ready;
  logic [14:0] rsp_p;
  logic        rsp_id, rsp_err;
  logic        exp_load, exp_start;
  logic [3:0]  exp_x, exp_a;
  logic        exp_done;
  logic [14:0] exp_p;
  logic        busy;
  logic [15:0] job_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int ref_last  = 1;
  int ref_count = 0;

  // Core model controls
  int core_delay = 4;
  bit core_never = 0;
  bit core_keep  = 0;
  bit core_busy;
  int core_cnt;

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  exponent_job_scheduler #(
    .X_W(4), .A_W(4), .P_W(15), .TIMEOUT(TOUT)
  ) dut (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_x        (req0_x),
    .req0_a        (req0_a),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_x        (req1_x),
    .req1_a        (req1_a),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_p         (rsp_p),
    .rsp_id        (rsp_id),
    .rsp_err       (rsp_err),
    .exp_load      (exp_load),
    .exp_start     (exp_start),
    .exp_x         (exp_x),
    .exp_a         (exp_a),
    .exp_done      (exp_done),
    .exp_p         (exp_p),
    .busy          (busy),
    .job_count     (job_count)
  );

  function automatic logic [14:0] ref_pow(input logic [3:0] x, input logic [3:0] a);
    longint r;
    r = 1;
    for (int i = 0; i < int'(a); i++) r = r * longint'(x);
    return r[14:0];
  endfunction

  // Behavioural exponent core: done rises core_delay cycles after start;
  // in keep mode the old done level lingers into the new job first.
  always @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      exp_done  <= 1'b0;
      exp_p     <= '0;
      core_busy <= 1'b0;
      core_cnt  <= 0;
    end else if (exp_start) begin
      core_busy <= 1'b1;
      core_cnt  <= 1;
      if (!core_keep) exp_done <= 1'b0;
    end else if (core_busy) begin
      core_cnt <= core_cnt + 1;
      if (core_keep && core_cnt == core_delay - 2) exp_done <= 1'b0;
      if (!core_never && core_cnt == core_delay) begin
        exp_done  <= 1'b1;
        exp_p     <= ref_pow(exp_x, exp_a);
        core_busy <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One complete job from request to response handshake
  task automatic run_job(input bit v0, input bit v1,
                         input logic [3:0] x0, input logic [3:0] a0,
                         input logic [3:0] x1, input logic [3:0] a1,
                         input int delay, input bit never, input bit keep,
                         input int hold);
    int g, lat, exp_lat;
    bit seen, rdy_ok, stable;
    logic [3:0] gx, ga;
    logic [14:0] ep;
    g  = (v0 && v1) ? (1 - ref_last) : (v1 ? 1 : 0);
    gx = (g == 1) ? x1 : x0;
    ga = (g == 1) ? a1 : a0;
    ep = never ? 15'd0 : ref_pow(gx, ga);
    exp_lat = never ? TOUT + 1 : delay + 2;

    @(negedge S_AXI_ACLK);
    core_delay = delay; core_never = never; core_keep = keep;
    req0_valid = v0; req0_x = x0; req0_a = a0;
    req1_valid = v1; req1_x = x1; req1_a = a1;
    #1;
    chk("ready0", req0_ready, (g == 0));
    chk("ready1", req1_ready, (g == 1));

    @(negedge S_AXI_ACLK);
    chk("load_cycle", {exp_load, exp_start, busy}, 3'b101);
    chk("operands", {exp_x, exp_a}, {gx, ga});

    @(negedge S_AXI_ACLK);
    chk("start_cycle", {exp_load, exp_start}, 2'b01);

    lat = 0; seen = 0; rdy_ok = 1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge S_AXI_ACLK);
      lat++;
      if (req0_ready || req1_ready) rdy_ok = 0;
      if (rsp_valid) seen = 1;
    end
    chk("rsp_within_budget", seen, 1);
    chk("latency", lat, exp_lat);
    chk("no_ready_while_busy", rdy_ok, 1);
    chk("rsp_fields", {rsp_p, rsp_id, rsp_err}, {ep, g[0], never});

    stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge S_AXI_ACLK);
      if (rsp_valid !== 1'b1 || {rsp_p, rsp_id, rsp_err} !== {ep, g[0], never} ||
          req0_ready || req1_ready || busy !== 1'b1) stable = 0;
    end
    chk("rsp_hold_stable", stable, 1);

    rsp_ready = 1; req0_valid = 0; req1_valid = 0;
    @(negedge S_AXI_ACLK);
    rsp_ready = 0;
    ref_last = g;
    ref_count++;
    chk("after_rsp", {rsp_valid, busy}, 2'b00);
    chk("job_count", job_count, ref_count[15:0]);
    $display("job %0d: id=%0d x=%0d a=%0d p=%0d err=%0d lat=%0d", ref_count, g, gx, ga, ep, never, lat);
  endtask

  initial begin
    int d, hold;
    bit v0, v1, cleared;
    S_AXI_ARESETN = 0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_x = 0; req0_a = 0; req1_x = 0; req1_a = 0;
    repeat (2) @(negedge S_AXI_ACLK);
    chk("reset_outputs", {rsp_valid, rsp_p, rsp_id, rsp_err, exp_load, exp_start, exp_x, exp_a, busy, job_count}, 0);
    chk("reset_ready", {req0_ready, req1_ready}, 2'b00);
    S_AXI_ARESETN = 1;

    // Single job: 3^2 = 9
    run_job(1, 0, 4'd3, 4'd2, 4'd0, 4'd0, 4, 0, 0, 0);
    // Fairness with both requesters continuously valid
    run_job(1, 1, 4'd2, 4'd5, 4'd7, 4'd2, 3, 0, 0, 1);
    run_job(1, 1, 4'd2, 4'd5, 4'd7, 4'd2, 2, 0, 0, 0);
    run_job(1, 1, 4'd2, 4'd5, 4'd7, 4'd2, 5, 0, 0, 0);
    // Core never finishes: timeout error
    run_job(0, 1, 4'd0, 4'd0, 4'd5, 4'd3, 4, 1, 0, 0);
    // Job that completes normally so done is left high afterwards
    run_job(1, 0, 4'd4, 4'd3, 4'd0, 4'd0, 2, 0, 0, 0);
    // Stale done level carried into this job must be ignored
    run_job(0, 1, 4'd0, 4'd0, 4'd6, 4'd2, 6, 0, 1, 0);
    // Consumer stalls for 10 cycles
    run_job(1, 1, 4'd3, 4'd4, 4'd2, 4'd9, 3, 0, 0, 10);

    // Randomized jobs
    for (int k = 0; k < 10; k++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1;
      d = $urandom_range(1, 10);
      hold = $urandom_range(0, 3);
      run_job(v0, v1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
              d, 0, (d >= 3) ? 1'($urandom_range(0, 1)) : 1'b0, hold);
    end

    // Reset while waiting on the core
    @(negedge S_AXI_ACLK);
    core_delay = 20; core_never = 0; core_keep = 0;
    req1_valid = 1; req1_x = 4'd3; req1_a = 4'd3;
    @(negedge S_AXI_ACLK);
    req1_valid = 0;
    repeat (4) @(negedge S_AXI_ACLK);
    chk("in_wait_busy", busy, 1);
    #2 S_AXI_ARESETN = 0;
    #1;
    chk("async_reset_outputs", {rsp_valid, rsp_p, rsp_id, rsp_err, exp_load, exp_start, exp_x, exp_a, busy, job_count}, 0);
    cleared = 1;
    repeat (2) @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1;
    ref_last = 1; ref_count = 0;
    repeat (25) begin
      @(negedge S_AXI_ACLK);
      if (rsp_valid || busy) cleared = 0;
    end
    chk("no_rsp_after_reset", cleared, 1);
    run_job(1, 1, 4'd2, 4'd3, 4'd3, 4'd2, 3, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
